seg7_scan_ctrl: RTL and testbench

//  Memory-mapped, N-digit multiplexed 7-segment display controller on the CPU IO bus.

---
 rtl/seg7_pkg.sv | 34 +++
 rtl/seg7_scan_timer.sv | 65 ++++++
 rtl/seg7_scan_ctrl.sv | 144 ++++++++++++++
 tb/tb_seg7_scan_ctrl.sv | 260 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/seg7_pkg.sv
// Shared definitions for the multiplexed 7-segment controller: register map
// indices and the hex font (segments a..g, bit6 = a).
package seg7_pkg;

    localparam logic [2:0] REG_DATA   = 3'd0;
    localparam logic [2:0] REG_DP     = 3'd1;
    localparam logic [2:0] REG_DIGEN  = 3'd2;
    localparam logic [2:0] REG_CTRL   = 3'd3;
    localparam logic [2:0] REG_STATUS = 3'd4;

    function automatic logic [6:0] seg7_font(input logic [3:0] v);
        logic [6:0] s;
        case (v)
            4'h0:    s = 7'h7E;
            4'h1:    s = 7'h30;
            4'h2:    s = 7'h6D;
            4'h3:    s = 7'h79;
            4'h4:    s = 7'h33;
            4'h5:    s = 7'h5B;
            4'h6:    s = 7'h5F;
            4'h7:    s = 7'h70;
            4'h8:    s = 7'h7F;
            4'h9:    s = 7'h7B;
            4'hA:    s = 7'h77;
            4'hB:    s = 7'h1F;
            4'hC:    s = 7'h4E;
            4'hD:    s = 7'h3D;
            4'hE:    s = 7'h4F;
            default: s = 7'h47;
        endcase
        return s;
    endfunction

endpackage

// File: rtl/seg7_scan_timer.sv
// Digit scan timebase: slot counter, current digit index, end-of-slot blanking
// window and the per-frame pulse/toggle.
module seg7_scan_timer #(
    parameter int NUM_DIGITS   = 2,
    parameter int DWELL_CYCLES = 65536,
    parameter int BLANK_CYCLES = 256
) (
    input  logic       clk,
    input  logic       resetn,
    output logic [2:0] dig_idx_o,
    output logic       blank_o,
    output logic       frame_o,
    output logic       frame_tog_o
);

    // One spare bit so DWELL_CYCLES itself is representable when BLANK_CYCLES is 0.
    localparam int CNT_W = $clog2(DWELL_CYCLES + 1);
    localparam logic [CNT_W-1:0] SLOT_LAST   = CNT_W'(DWELL_CYCLES - 1);
    localparam logic [CNT_W-1:0] BLANK_START = CNT_W'(DWELL_CYCLES - BLANK_CYCLES);
    localparam logic [2:0]       DIG_LAST    = 3'(NUM_DIGITS - 1);

    logic [CNT_W-1:0] slot_cnt_q, slot_cnt_d;
    logic [2:0]       dig_idx_q, dig_idx_d;
    logic             frame_q, frame_d;
    logic             frame_tog_q, frame_tog_d;
    logic             slot_wrap;

    assign slot_wrap = (slot_cnt_q == SLOT_LAST);

    always_comb begin
        slot_cnt_d  = slot_cnt_q + 1'b1;
        dig_idx_d   = dig_idx_q;
        frame_d     = 1'b0;
        if (slot_wrap) begin
            slot_cnt_d = '0;
            if (dig_idx_q == DIG_LAST) begin
                dig_idx_d = 3'd0;
                frame_d   = 1'b1;
            end else begin
                dig_idx_d = dig_idx_q + 3'd1;
            end
        end
        frame_tog_d = frame_tog_q ^ frame_d;
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            slot_cnt_q  <= '0;
            dig_idx_q   <= 3'd0;
            frame_q     <= 1'b0;
            frame_tog_q <= 1'b0;
        end else begin
            slot_cnt_q  <= slot_cnt_d;
            dig_idx_q   <= dig_idx_d;
            frame_q     <= frame_d;
            frame_tog_q <= frame_tog_d;
        end
    end

    assign dig_idx_o   = dig_idx_q;
    assign blank_o     = (slot_cnt_q >= BLANK_START);
    assign frame_o     = frame_q;
    assign frame_tog_o = frame_tog_q;

endmodule

// File: rtl/seg7_scan_ctrl.sv
// Bus-mapped N-digit multiplexed 7-segment controller: register file,
// leading-zero suppression and the registered SEG/COM output stage.
module seg7_scan_ctrl
    import seg7_pkg::*;
#(
    parameter int NUM_DIGITS     = 2,
    parameter int DWELL_CYCLES   = 65536,
    parameter int BLANK_CYCLES   = 256,
    parameter int SEG_ACTIVE_LOW = 0,
    parameter int COM_ACTIVE_LOW = 0
) (
    input  logic                  clk,
    input  logic                  resetn,
    input  logic                  valid,
    input  logic [2:0]            addr,
    input  logic [31:0]           wdata,
    input  logic                  wstrb,
    output logic [31:0]           rdata,
    output logic [7:0]            seg_o,
    output logic [NUM_DIGITS-1:0] com_o,
    output logic                  frame_o
);

    localparam int DW = 4 * NUM_DIGITS;

    logic [DW-1:0]         data_q, data_d;
    logic [NUM_DIGITS-1:0] dp_q, dp_d;
    logic [NUM_DIGITS-1:0] digen_q, digen_d;
    logic [1:0]            ctrl_q, ctrl_d;
    logic [31:0]           rdata_q, rdata_d;
    logic [7:0]            seg_q, seg_d;
    logic [NUM_DIGITS-1:0] com_q, com_d;

    logic [2:0] dig_idx;
    logic       blank;
    logic       frame_tog;
    logic       unused_wdata;

    seg7_scan_timer #(
        .NUM_DIGITS  (NUM_DIGITS),
        .DWELL_CYCLES(DWELL_CYCLES),
        .BLANK_CYCLES(BLANK_CYCLES)
    ) u_timer (
        .clk        (clk),
        .resetn     (resetn),
        .dig_idx_o  (dig_idx),
        .blank_o    (blank),
        .frame_o    (frame_o),
        .frame_tog_o(frame_tog)
    );

    // Per-digit views padded to 8 entries so a 3-bit index is always in range.
    logic [3:0] nib [8];
    logic [7:0] dp_x;
    logic [7:0] digen_x;
    logic [8:0] hi_zero;
    logic [7:0] suppress;

    assign hi_zero[8] = 1'b1;

    for (genvar gi = 0; gi < 8; gi++) begin : g_digit
        if (gi < NUM_DIGITS) begin : g_real
            assign nib[gi]     = data_q[4*gi +: 4];
            assign dp_x[gi]    = dp_q[gi];
            assign digen_x[gi] = digen_q[gi];
        end else begin : g_pad
            assign nib[gi]     = 4'h0;
            assign dp_x[gi]    = 1'b0;
            assign digen_x[gi] = 1'b0;
        end
        // hi_zero[i]: every enabled digit from i upward holds zero.
        assign hi_zero[gi] = hi_zero[gi+1] && ((nib[gi] == 4'h0) || !digen_x[gi]);
        if (gi == 0) begin : g_lsd
            assign suppress[gi] = 1'b0;
        end else begin : g_upper
            assign suppress[gi] = (nib[gi] == 4'h0) && hi_zero[gi+1];
        end
    end

    always_comb begin
        data_d  = data_q;
        dp_d    = dp_q;
        digen_d = digen_q;
        ctrl_d  = ctrl_q;
        if (valid && wstrb) begin
            case (addr)
                REG_DATA:  data_d  = wdata[DW-1:0];
                REG_DP:    dp_d    = wdata[NUM_DIGITS-1:0];
                REG_DIGEN: digen_d = wdata[NUM_DIGITS-1:0];
                REG_CTRL:  ctrl_d  = wdata[1:0];
                default:   ;
            endcase
        end
    end

    always_comb begin
        case (addr)
            REG_DATA:   rdata_d = 32'(data_q);
            REG_DP:     rdata_d = 32'(dp_q);
            REG_DIGEN:  rdata_d = 32'(digen_q);
            REG_CTRL:   rdata_d = {30'd0, ctrl_q};
            REG_STATUS: rdata_d = {23'd0, frame_tog, 5'd0, dig_idx};
            default:    rdata_d = 32'd0;
        endcase
    end

    always_comb begin
        seg_d = 8'h00;
        com_d = '0;
        if (ctrl_q[0] && digen_x[dig_idx] && !blank) begin
            com_d = NUM_DIGITS'(1) << dig_idx;
            seg_d = {(ctrl_q[1] && suppress[dig_idx]) ? 7'h00 : seg7_font(nib[dig_idx]),
                     dp_x[dig_idx]};
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            data_q  <= '0;
            dp_q    <= '0;
            digen_q <= '0;
            ctrl_q  <= 2'b00;
            rdata_q <= 32'd0;
            seg_q   <= 8'h00;
            com_q   <= '0;
        end else begin
            data_q  <= data_d;
            dp_q    <= dp_d;
            digen_q <= digen_d;
            ctrl_q  <= ctrl_d;
            rdata_q <= rdata_d;
            seg_q   <= seg_d;
            com_q   <= com_d;
        end
    end

    // Polarity is applied after the register so reset/inactive levels invert too.
    assign rdata = rdata_q;
    assign seg_o = (SEG_ACTIVE_LOW != 0) ? ~seg_q : seg_q;
    assign com_o = (COM_ACTIVE_LOW != 0) ? ~com_q : com_q;

    assign unused_wdata = ^wdata;

endmodule

// File: tb/tb_seg7_scan_ctrl.sv
// Scoreboard bench for seg7_scan_ctrl: one active-high and one active-low
// instance share the bus; expectations are queued with their due cycle.
module tb_seg7_scan_ctrl;

    localparam int ND = 4;
    localparam int DW = 16;
    localparam int BL = 2;

    logic          clk = 1'b0;
    logic          resetn = 1'b0;
    logic          valid = 1'b0;
    logic          wstrb = 1'b0;
    logic [2:0]    addr = 3'd0;
    logic [31:0]   wdata = 32'd0;
    logic [31:0]   rdata, rdata_n;
    logic [7:0]    seg, seg_n;
    logic [ND-1:0] com, com_n;
    logic          frame, frame_n;

    int cyc = 0;
    int n_checks = 0;
    int n_fail = 0;
    int rel_cyc = 0;

    typedef struct {
        int          cyc;
        int          kind;
        logic [31:0] exp;
        string       name;
    } exp_t;

    exp_t sb[$];

    seg7_scan_ctrl #(
        .NUM_DIGITS(ND), .DWELL_CYCLES(DW), .BLANK_CYCLES(BL),
        .SEG_ACTIVE_LOW(0), .COM_ACTIVE_LOW(0)
    ) dut (
        .clk(clk), .resetn(resetn), .valid(valid), .addr(addr), .wdata(wdata),
        .wstrb(wstrb), .rdata(rdata), .seg_o(seg), .com_o(com), .frame_o(frame)
    );

    seg7_scan_ctrl #(
        .NUM_DIGITS(ND), .DWELL_CYCLES(DW), .BLANK_CYCLES(BL),
        .SEG_ACTIVE_LOW(1), .COM_ACTIVE_LOW(1)
    ) dut_n (
        .clk(clk), .resetn(resetn), .valid(valid), .addr(addr), .wdata(wdata),
        .wstrb(wstrb), .rdata(rdata_n), .seg_o(seg_n), .com_o(com_n), .frame_o(frame_n)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic void chk(input string nm, input logic [31:0] act, input logic [31:0] want);
        n_checks++;
        if (act !== want) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, want, cyc);
        end
    endfunction

    task automatic push(input int c, input int kind, input logic [31:0] e, input string nm);
        exp_t x;
        x.cyc = c; x.kind = kind; x.exp = e; x.name = nm;
        sb.push_back(x);
    endtask

    task automatic push_disp(input int c, input logic [11:0] e, input string nm);
        push(c, 0, 32'(e), nm);
        push(c, 1, 32'(e ^ 12'hFFF), {nm, "_inv"});
    endtask

    // Monitor: compare every queued expectation whose cycle has arrived.
    always @(negedge clk) begin
        exp_t e;
        logic [31:0] act;
        for (int i = sb.size() - 1; i >= 0; i--) begin
            if (sb[i].cyc <= cyc) begin
                e = sb[i];
                sb.delete(i);
                if (e.cyc < cyc) begin
                    chk({"late_", e.name}, 32'(cyc), 32'(e.cyc));
                end else begin
                    case (e.kind)
                        0:       act = {20'd0, com, seg};
                        1:       act = {20'd0, com_n, seg_n};
                        2:       act = rdata;
                        3:       act = {31'd0, frame};
                        4:       act = rdata_n;
                        default: act = {31'd0, frame_n};
                    endcase
                    chk(e.name, act, e.exp);
                    $display("txn cyc=%0d %s act=%h exp=%h", cyc, e.name, act, e.exp);
                end
            end
        end
    end

    task automatic go_cycle(input int c);
        while (cyc < c) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic bus_write(input logic [2:0] a, input logic [31:0] d);
        valid = 1'b1; wstrb = 1'b1; addr = a; wdata = d;
        @(posedge clk);
        #1;
        valid = 1'b0; wstrb = 1'b0;
    endtask

    task automatic bus_read(input logic [2:0] a, input logic [31:0] e, input string nm);
        valid = 1'b1; wstrb = 1'b0; addr = a;
        push(cyc + 1, 2, e, nm);
        @(posedge clk);
        #1;
        valid = 1'b0;
    endtask

    task automatic wait_frame(output int f);
        f = -1;
        for (int n = 0; n < 200; n++) begin
            @(negedge clk);
            if (frame) begin
                f = cyc;
                break;
            end
        end
        if (f < 0) begin
            chk("frame_timeout", 32'd0, 32'd1);
            f = cyc;
        end
    endtask

    // STATUS derived from elapsed cycles since reset release: 16 per digit, 64 per frame.
    function automatic logic [31:0] exp_status(input int c);
        int s;
        s = c - rel_cyc;
        return {23'd0, 1'((s / 64) & 1), 5'd0, 3'((s / 16) % 4)};
    endfunction

    localparam logic [11:0] S2 [4] = '{12'h160, 12'h28E, 12'h4F2, 12'h8EE};
    localparam logic [11:0] S3 [4] = '{12'h1FC, 12'h2B7, 12'h400, 12'h800};

    initial begin
        int f;
        logic [11:0] s2v [4];
        logic [11:0] s3v [4];
        s2v = S2;
        s3v = S3;

        // Reset held.
        go_cycle(3);
        push_disp(4, 12'h000, "rst_disp");
        push(4, 2, 32'd0, "rst_rdata");
        push(4, 4, 32'd0, "rst_rdata_inv");
        push(4, 3, 32'd0, "rst_frame");
        go_cycle(5);
        resetn = 1'b1;
        rel_cyc = cyc;

        // Idle scan: outputs inactive, STATUS walks the digits.
        wait_frame(f);
        chk("first_frame_cycle", 32'(f), 32'(rel_cyc + 64));
        push_disp(f + 3, 12'h000, "idle_disp_a");
        push_disp(f + 40, 12'h000, "idle_disp_b");
        for (int k = 0; k < 5; k++) begin
            go_cycle(f + 1 + 16 * k);
            bus_read(REG_IDX_STATUS(), exp_status(cyc), "status_walk");
        end

        // Normal display, blanking windows, frame pulse.
        bus_write(3'd0, 32'h0000A3F1);
        bus_write(3'd2, 32'h0000000F);
        bus_write(3'd3, 32'h00000001);
        wait_frame(f);
        for (int d = 0; d < 4; d++) begin
            push_disp(f + 16 * d + 2, s2v[d], "disp_early");
            push_disp(f + 16 * d + 14, s2v[d], "disp_last");
            push_disp(f + 16 * d + 15, 12'h000, "blank_a");
            push_disp(f + 16 * d + 16, 12'h000, "blank_b");
        end
        for (int c = f + 1; c <= f + 64; c++) begin
            push(c, 3, 32'(c == f + 64), "frame_pulse");
            push(c, 5, 32'(c == f + 64), "frame_pulse_inv");
        end
        go_cycle(f + 63);
        bus_read(3'd4, exp_status(cyc), "status_pre_frame");
        bus_read(3'd4, exp_status(cyc), "status_post_frame");

        // Leading-zero suppression with decimal point.
        bus_write(3'd0, 32'h00000050);
        bus_write(3'd1, 32'h00000002);
        bus_write(3'd3, 32'h00000003);
        wait_frame(f);
        for (int d = 0; d < 4; d++) push_disp(f + 16 * d + 5, s3v[d], "lzs_disp");
        go_cycle(f + 66);

        // Register access.
        bus_write(3'd0, 32'hFFFF1234);
        bus_read(3'd0, 32'h00001234, "rd_data");
        bus_write(3'd1, 32'hFFFFFFFF);
        bus_read(3'd1, 32'h0000000F, "rd_dp");
        bus_write(3'd2, 32'hFFFFFFF5);
        bus_read(3'd2, 32'h00000005, "rd_digen");
        bus_write(3'd3, 32'hFFFFFFFE);
        bus_read(3'd3, 32'h00000002, "rd_ctrl");
        bus_write(3'd6, 32'hFFFFFFFF);
        bus_read(3'd6, 32'h00000000, "rd_rsvd6");
        bus_read(3'd5, 32'h00000000, "rd_rsvd5");
        bus_write(3'd4, 32'hFFFFFFFF);
        bus_read(3'd4, exp_status(cyc), "rd_status_ro");

        // Clearing EN mid-slot.
        bus_write(3'd0, 32'h0000A3F1);
        bus_write(3'd1, 32'h00000000);
        bus_write(3'd2, 32'h0000000F);
        bus_write(3'd3, 32'h00000001);
        wait_frame(f);
        go_cycle(f + 5);
        push_disp(f + 6, 12'h160, "en_before");
        push_disp(f + 7, 12'h000, "en_cleared");
        push_disp(f + 8, 12'h000, "en_cleared2");
        bus_write(3'd3, 32'h00000000);
        go_cycle(f + 10);

        // Asynchronous reset mid-slot.
        bus_write(3'd3, 32'h00000001);
        wait_frame(f);
        go_cycle(f + 5);
        chk("pre_rst_disp", {20'd0, com, seg}, 32'h160);
        chk("pre_rst_disp_inv", {20'd0, com_n, seg_n}, 32'hE9F);
        #3;
        resetn = 1'b0;
        #1;
        chk("async_rst_disp", {20'd0, com, seg}, 32'h000);
        chk("async_rst_disp_inv", {20'd0, com_n, seg_n}, 32'hFFF);
        chk("async_rst_frame", {31'd0, frame}, 32'd0);
        go_cycle(cyc + 3);
        resetn = 1'b1;
        go_cycle(cyc + 3);

        chk("sb_drain", 32'(sb.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

    function automatic logic [2:0] REG_IDX_STATUS();
        return 3'd4;
    endfunction

    initial begin
        #100000;
        chk("watchdog", 32'd0, 32'd1);
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
